// File: rtl/branch_addr_bus_reader_pkg.sv
// -----------------------------------------------------------------------------
// branch_addr_bus_reader_pkg
// Shared definitions for the branch-address bus reader:
//   rd_state_e   - reader FSM state encoding (binary, 5 states)
//   CS_IDLE      - all-ones select pattern (every source floats the bus)
//   MAX_SETTLE   - largest supported settle time in Tick cycles
//   CNT_W        - width of the settle down-counter
//   settle_load  - converts a settle time into the counter load value
// -----------------------------------------------------------------------------
package branch_addr_bus_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } rd_state_e;

  // Wide enough for the largest bank (16 sources); users slice what they need.
  localparam logic [15:0] CS_IDLE    = '1;
  localparam int          MAX_SETTLE = 15;
  localparam int          CNT_W      = 4;

  // The counter is loaded with (cycles - 1) so that it reaches zero exactly
  // when the settle window has elapsed. Out-of-range values are clamped.
  function automatic logic [CNT_W-1:0] settle_load(input int cycles);
    int c;
    c = cycles;
    if (c < 1)          c = 1;
    if (c > MAX_SETTLE) c = MAX_SETTLE;
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/branch_addr_bus_reader_if.sv
// -----------------------------------------------------------------------------
// branch_addr_bus_reader_if
// Signal bundle between the bus reader, the tri-state register bank and the
// fetch/branch consumer.
//   Req/ReqSel          read request and source index
//   cs                  per-source select, active-low (1 = source floats bus)
//   Bus                 shared tri-state bus
//   DataOut/DataValid   captured value towards the consumer
//   DataReady           consumer accept
//   Busy                reader not idle
//   SelErr              request named a source that does not exist
// Modports:
//   master - the reader (drives cs and the consumer-side outputs)
//   slave  - the surrounding system (requester, register bank, consumer)
// -----------------------------------------------------------------------------
interface branch_addr_bus_reader_if #(
  parameter int NrOfBits    = 32,
  parameter int NrOfSources = 4,
  parameter int SelBits     = 2
);

  logic                   Req;
  logic [SelBits-1:0]     ReqSel;
  logic [NrOfSources-1:0] cs;
  logic [NrOfBits-1:0]    Bus;
  logic [NrOfBits-1:0]    DataOut;
  logic                   DataValid;
  logic                   DataReady;
  logic                   Busy;
  logic                   SelErr;

  modport master (
    input  Req, ReqSel, Bus, DataReady,
    output cs, DataOut, DataValid, Busy, SelErr
  );

  modport slave (
    output Req, ReqSel, Bus, DataReady,
    input  cs, DataOut, DataValid, Busy, SelErr
  );

endinterface

// File: rtl/branch_addr_bus_reader_bus_settle_counter.sv
// -----------------------------------------------------------------------------
// bus_settle_counter
// 4-bit down-counter timing the bus settle window.
//   Clock     in  system clock, rising edge
//   Reset     in  asynchronous, active-high
//   tick      in  advance enable; nothing changes on edges with tick=0
//   load      in  load load_val (has priority over dec)
//   dec       in  decrement by one, saturating at zero
//   load_val  in  value to load
//   zero      out count is zero
// -----------------------------------------------------------------------------
module bus_settle_counter
  import branch_addr_bus_reader_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             tick,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of its peers, independent of process evaluation order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      if (load) begin
        cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/branch_addr_bus_reader.sv
// -----------------------------------------------------------------------------
// branch_addr_bus_reader
// Reader side of the shared tri-state branch-address register bus. Selects one
// source with an active-low cs line, waits for the bus to settle, captures the
// bus value and offers it to the fetch/branch unit over valid/ready.
//   Clock   in   system clock, rising edge
//   Reset   in   asynchronous, active-high
//   Tick    in   advance enable; state changes only on edges with Tick=1
//   rd      master modport of branch_addr_bus_reader_if:
//             Req, ReqSel, Bus, DataReady  (in)
//             cs, DataOut, DataValid, Busy, SelErr  (out, all registered)
//
// Timing (Tick edges, SettleCycles = S):
//   e1        IDLE -> SELECT, cs[idx] driven low, settle count = S-1
//   e2        SELECT -> SETTLE
//   e3..eS+1  count decrements
//   eS+2      count at zero: capture Bus, DataValid=1, cs released -> CAPTURE
//   next      CAPTURE -> HOLD; HOLD waits for DataReady, then back to IDLE
// -----------------------------------------------------------------------------
module branch_addr_bus_reader
  import branch_addr_bus_reader_pkg::*;
#(
  parameter int NrOfBits     = 32,
  parameter int NrOfSources  = 4,
  parameter int SelBits      = 2,
  parameter int SettleCycles = 1
) (
  input logic                      Clock,
  input logic                      Reset,
  input logic                      Tick,
  branch_addr_bus_reader_if.master rd
);

  localparam logic [NrOfSources-1:0] CS_ALL      = CS_IDLE[NrOfSources-1:0];
  localparam logic [CNT_W-1:0]       SETTLE_LOAD = settle_load(SettleCycles);

  // Active-low one-hot select pattern for a source index.
  function automatic logic [NrOfSources-1:0] sel_mask(input logic [SelBits-1:0] sel);
    logic [NrOfSources-1:0] m;
    for (int i = 0; i < NrOfSources; i++) begin
      m[i] = (i != int'(sel));
    end
    return m;
  endfunction

  rd_state_e              state_q, state_d;
  logic [SelBits-1:0]     idx_q, idx_d;
  logic [NrOfSources-1:0] cs_q, cs_d;
  logic [NrOfBits-1:0]    data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   sel_err_q, sel_err_d;
  logic                   cnt_load, cnt_dec, cnt_zero;
  logic                   sel_ok;

  assign sel_ok = (int'(rd.ReqSel) < NrOfSources);

  bus_settle_counter u_settle (
    .Clock    (Clock),
    .Reset    (Reset),
    .tick     (Tick),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (SETTLE_LOAD),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else if (Tick) begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cs_d      = cs_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sel_err_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rd.Req) begin
          if (sel_ok) begin
            // cs drops on the same edge that enters SELECT; the counter is
            // loaded together with it so SETTLE starts at S-1.
            idx_d    = rd.ReqSel;
            cs_d     = sel_mask(rd.ReqSel);
            cnt_load = 1'b1;
            state_d  = ST_SELECT;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end

      ST_SELECT: begin
        cs_d    = sel_mask(idx_q);
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          // The only place Bus is looked at: the edge entering CAPTURE.
          // Releasing cs on this same edge gives break-before-make.
          data_d  = rd.Bus;
          valid_d = 1'b1;
          cs_d    = CS_ALL;
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (rd.DataReady) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        cs_d    = CS_ALL;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Output and datapath registers; Reset releases cs straight from the flop.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      idx_q     <= '0;
      cs_q      <= CS_ALL;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else if (Tick) begin
      idx_q     <= idx_d;
      cs_q      <= cs_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign rd.cs        = cs_q;
  assign rd.DataOut   = data_q;
  assign rd.DataValid = valid_q;
  assign rd.Busy      = busy_q;
  assign rd.SelErr    = sel_err_q;

endmodule
